// File: rtl/zeroskip_pkg.sv
// rtl/zeroskip_pkg.sv - shared zero-skip constants, lane types and packer state enum
package zeroskip_pkg;

  localparam int ZS_DATA_W       = 8;
  localparam int ZS_GROUP_NZ_MAX = 16;
  localparam int ZS_OUT_LANES    = 16;

  typedef logic [ZS_DATA_W-1:0]              act_t;
  typedef logic [$clog2(ZS_GROUP_NZ_MAX):0]  cnt_t;

  typedef enum logic {
    FILL  = 1'b0,
    FLUSH = 1'b1
  } packer_state_e;

  function automatic int unsigned zs_min(int unsigned a, int unsigned b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/zeroskip_lane_shifter.sv
// rtl/zeroskip_lane_shifter.sv - drops pop_cnt head lanes and appends ins_cnt lanes at ins_off
// Lanes at and above ins_off are zero after the shift, so the insert is a plain OR.
module zeroskip_lane_shifter #(
  parameter int GROUP_NZ_MAX = 16,
  parameter int DATA_W       = 8,
  parameter int BUF_LANES    = 32,
  parameter int CNT_W        = 6
) (
  input  logic [BUF_LANES*DATA_W-1:0]    buf_in,
  input  logic [CNT_W-1:0]               pop_cnt,
  input  logic [CNT_W-1:0]               ins_off,
  input  logic [CNT_W-1:0]               ins_cnt,
  input  logic [GROUP_NZ_MAX*DATA_W-1:0] ins_data,
  output logic [BUF_LANES*DATA_W-1:0]    buf_out
);

  logic [BUF_LANES*DATA_W-1:0] shifted;
  logic [BUF_LANES*DATA_W-1:0] ins_wide;

  always_comb begin
    shifted  = buf_in >> (pop_cnt * DATA_W);
    ins_wide = '0;
    for (int j = 0; j < GROUP_NZ_MAX; j++) begin
      if (CNT_W'(j) < ins_cnt) begin
        ins_wide[j*DATA_W +: DATA_W] = ins_data[j*DATA_W +: DATA_W];
      end
    end
    buf_out = shifted | (ins_wide << (ins_off * DATA_W));
  end

endmodule

// File: rtl/zeroskip_packer.sv
// rtl/zeroskip_packer.sv - repacks variable-length zero-skip groups into dense fixed-width beats
// Optional counters: define ZEROSKIP_PACKER_STATS_EN to enable stat_elems/stat_beats.
module zeroskip_packer
  import zeroskip_pkg::*;
#(
  parameter int GROUP_NZ_MAX = ZS_GROUP_NZ_MAX,
  parameter int DATA_W       = ZS_DATA_W,
  parameter int OUT_LANES    = ZS_OUT_LANES
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [GROUP_NZ_MAX*DATA_W-1:0]   in_data,
  input  logic [$clog2(GROUP_NZ_MAX):0]    in_cnt,
  input  logic                             in_last,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [OUT_LANES*DATA_W-1:0]      out_data,
  output logic [$clog2(OUT_LANES):0]       out_cnt,
  output logic                             out_last,
  output logic [31:0]                      stat_elems,
  output logic [31:0]                      stat_beats
);

  localparam int BUF_LANES = GROUP_NZ_MAX + OUT_LANES;
  localparam int FILL_W    = $clog2(BUF_LANES) + 1;
  localparam int ICNT_W    = $clog2(GROUP_NZ_MAX) + 1;
  localparam int OCNT_W    = $clog2(OUT_LANES) + 1;

  logic [BUF_LANES*DATA_W-1:0] buf_q, buf_d, buf_shifted;
  logic [FILL_W-1:0]           fill_q, fill_d;
  packer_state_e               state_q, state_d;
  logic                        out_valid_q, out_valid_d;
  logic                        out_last_q, out_last_d;
  logic [OCNT_W-1:0]           out_cnt_q, out_cnt_d;
  logic [OUT_LANES*DATA_W-1:0] out_data_q, out_data_d;

  logic              pop, push;
  logic [FILL_W-1:0] pop_cnt, push_cnt, fill_pop;

  always_comb begin
    in_ready = (state_q == FILL) && (fill_q <= FILL_W'(OUT_LANES));
    pop      = out_valid_q && out_ready;
    push     = in_valid && in_ready;
    pop_cnt  = pop ? FILL_W'(out_cnt_q) : '0;
    push_cnt = '0;
    if (push) begin
      push_cnt = (in_cnt > ICNT_W'(GROUP_NZ_MAX)) ? FILL_W'(GROUP_NZ_MAX) : FILL_W'(in_cnt);
    end
    fill_pop = fill_q - pop_cnt;
  end

  zeroskip_lane_shifter #(
    .GROUP_NZ_MAX (GROUP_NZ_MAX),
    .DATA_W       (DATA_W),
    .BUF_LANES    (BUF_LANES),
    .CNT_W        (FILL_W)
  ) u_shifter (
    .buf_in   (buf_q),
    .pop_cnt  (pop_cnt),
    .ins_off  (fill_pop),
    .ins_cnt  (push_cnt),
    .ins_data (in_data),
    .buf_out  (buf_shifted)
  );

  // Output registers are computed from next state so out_* always mirror buf_q/fill_q.
  always_comb begin
    state_d = state_q;
    fill_d  = fill_pop + push_cnt;
    buf_d   = buf_shifted;
    if (state_q == FILL && push && in_last) begin
      state_d = FLUSH;
    end
    if (state_q == FLUSH && pop && out_last_q) begin
      state_d = FILL;
      fill_d  = '0;
      buf_d   = '0;
    end

    if (state_d == FLUSH) begin
      out_valid_d = 1'b1;
      out_cnt_d   = OCNT_W'(zs_min(32'(fill_d), OUT_LANES));
      out_last_d  = (fill_d <= FILL_W'(OUT_LANES));
    end else begin
      out_valid_d = (fill_d >= FILL_W'(OUT_LANES));
      out_cnt_d   = out_valid_d ? OCNT_W'(OUT_LANES) : '0;
      out_last_d  = 1'b0;
    end
    out_data_d = out_valid_d ? buf_d[OUT_LANES*DATA_W-1:0] : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_q       <= '0;
      fill_q      <= '0;
      state_q     <= FILL;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_cnt_q   <= '0;
      out_data_q  <= '0;
    end else begin
      buf_q       <= buf_d;
      fill_q      <= fill_d;
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_cnt_q   <= out_cnt_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_cnt   = out_cnt_q;
  assign out_data  = out_data_q;

`ifdef ZEROSKIP_PACKER_STATS_EN
  logic [31:0] stat_elems_q, stat_elems_d;
  logic [31:0] stat_beats_q, stat_beats_d;

  always_comb begin
    stat_elems_d = stat_elems_q + 32'(push_cnt);
    stat_beats_d = stat_beats_q + (pop ? 32'd1 : 32'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_elems_q <= '0;
      stat_beats_q <= '0;
    end else begin
      stat_elems_q <= stat_elems_d;
      stat_beats_q <= stat_beats_d;
    end
  end

  assign stat_elems = stat_elems_q;
  assign stat_beats = stat_beats_q;
`else
  assign stat_elems = '0;
  assign stat_beats = '0;
`endif

  a_in_cnt_legal: assert property (@(posedge clk) disable iff (rst)
    (in_valid && in_ready) |-> (in_cnt <= ICNT_W'(GROUP_NZ_MAX)));

endmodule

// File: tb/tb_zeroskip_packer.sv
// tb/tb_zeroskip_packer.sv - scoreboard bench: directed tiles plus random tiles vs an element-stream model
module tb_zeroskip_packer;

  localparam int GN = 16;
  localparam int DW = 8;
  localparam int OL = 16;

  typedef struct {
    int                 cnt;
    bit                 last;
    logic [OL*DW-1:0]   data;
  } beat_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [GN*DW-1:0]  in_data = '0;
  logic [4:0]        in_cnt = '0;
  logic              in_last = 1'b0;
  logic              out_valid;
  logic              out_ready;
  logic [OL*DW-1:0]  out_data;
  logic [4:0]        out_cnt;
  logic              out_last;
  logic [31:0]       stat_elems, stat_beats;

  int vectors = 0;
  int miscompares = 0;
  int rdy_mode = 0;
  int sum_elems = 0;
  int beats_seen = 0;
  logic [7:0] pend[$];
  beat_t      exp_q[$];

  zeroskip_packer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_cnt(in_cnt), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_cnt(out_cnt), .out_last(out_last),
    .stat_elems(stat_elems), .stat_beats(stat_beats)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [OL*DW-1:0] act, input logic [OL*DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Tile stream model: a tile is cut into 16-element beats, the last one flagged.
  task automatic push_beat(input int n, input bit last);
    beat_t b;
    b.data = '0;
    for (int i = 0; i < n; i++) b.data[i*DW +: DW] = pend.pop_front();
    b.cnt  = n;
    b.last = last;
    exp_q.push_back(b);
  endtask

  task automatic model_accept(input logic [GN*DW-1:0] d, input int cnt, input bit last);
    for (int j = 0; j < cnt; j++) pend.push_back(d[j*DW +: DW]);
    sum_elems += cnt;
    if (!last) begin
      while (pend.size() >= OL) push_beat(OL, 1'b0);
    end else begin
      while (pend.size() > OL) push_beat(OL, 1'b0);
      push_beat(pend.size(), 1'b1);
    end
  endtask

  task automatic send_group(input int cnt, input bit last);
    logic [GN*DW-1:0] d;
    int  waited;
    bit  got;
    d = '0;
    for (int j = 0; j < cnt; j++) d[j*DW +: DW] = 8'($urandom_range(1, 255));
    in_data  = d;
    in_cnt   = 5'(cnt);
    in_last  = last;
    in_valid = 1'b1;
    waited = 0;
    got = 1'b0;
    while (!got && waited < 2000) begin
      @(negedge clk);
      if (in_ready) got = 1'b1;
      else waited++;
    end
    if (!got) begin
      vectors++;
      miscompares++;
      $display("FAIL accept_timeout: in_ready stuck at %0d, required 1", in_ready);
    end else begin
      @(posedge clk);
      model_accept(d, cnt, last);
    end
    #1;
    in_valid = 1'b0;
    in_data  = '0;
    in_cnt   = '0;
    in_last  = 1'b0;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    pend.delete();
    exp_q.delete();
    sum_elems  = 0;
    beats_seen = 0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_cnt", out_cnt, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_stat_elems", stat_elems, 0);
    chk("rst_stat_beats", stat_beats, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while ((exp_q.size() != 0 || out_valid) && w < 3000) begin
      @(posedge clk);
      w++;
    end
    #1;
    chk("drain_pending_beats", exp_q.size(), 0);
  endtask

  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(0, 3) != 0);
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: checks every consumed beat against the scoreboard and hold-stability under stall.
  initial begin
    bit               prev_stall;
    logic [OL*DW-1:0] held_data;
    logic [4:0]       held_cnt;
    beat_t            b;
    prev_stall = 1'b0;
    held_data  = '0;
    held_cnt   = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("hold_valid", out_valid, 1);
          chk("hold_data", out_data, held_data);
          chk("hold_cnt", out_cnt, held_cnt);
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_beat: cnt %0d last %0d with no beat expected", out_cnt, out_last);
          end else begin
            b = exp_q.pop_front();
            chk("beat_cnt", out_cnt, b.cnt);
            chk("beat_last", out_last, b.last);
            chk("beat_data", out_data, b.data);
            beats_seen++;
          end
        end
        prev_stall = out_valid && !out_ready;
        held_data  = out_data;
        held_cnt   = out_cnt;
      end
    end
  end

  initial begin
    int idle_beats;
    int ng;
    do_reset();

    idle_beats = 0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid) idle_beats++;
    end
    chk("idle_no_beat", idle_beats, 0);
    @(posedge clk);
    #1;

    // Partial tile discarded by reset.
    send_group(10, 1'b0);
    do_reset();
    repeat (5) @(posedge clk);
    #1;
    chk("post_reset_no_beat", out_valid, 0);

    rdy_mode = 0;
    send_group(10, 1'b0);
    send_group(6, 1'b1);
    drain();
    send_group(16, 1'b0);
    send_group(16, 1'b0);
    send_group(3, 1'b1);
    drain();
    send_group(0, 1'b1);
    drain();

    // Backpressure: two full groups fill the buffer and must close in_ready.
    rdy_mode = 2;
    repeat (2) @(posedge clk);
    #1;
    send_group(16, 1'b0);
    @(negedge clk);
    chk("in_ready_at_fill16", in_ready, 1);
    @(posedge clk);
    #1;
    send_group(16, 1'b0);
    @(negedge clk);
    chk("in_ready_bp", in_ready, 0);
    chk("out_valid_bp", out_valid, 1);
    repeat (10) @(posedge clk);
    #1;
    rdy_mode = 0;
    send_group(5, 1'b1);
    drain();

    rdy_mode = 1;
    for (int t = 0; t < 40; t++) begin
      ng = $urandom_range(0, 6);
      for (int g = 0; g < ng; g++) begin
        send_group($urandom_range(0, 16), 1'b0);
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #0;
      end
      if (ng == 0) send_group(0, 1'b1);
      else         send_group($urandom_range(1, 16), 1'b1);
    end
    rdy_mode = 0;
    drain();

`ifdef ZEROSKIP_PACKER_STATS_EN
    chk("stat_elems", stat_elems, 32'(sum_elems));
    chk("stat_beats", stat_beats, 32'(beats_seen));
`else
    chk("stat_elems_off", stat_elems, 0);
    chk("stat_beats_off", stat_beats, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
